// File: rtl/fpu_ret_collect_pkg.sv
// Shared constants and types for the FPU return-port collector.
package fpu_ret_collect_pkg;

   localparam int unsigned TagW     = 14;
   localparam int unsigned DepthDef = 4;
   localparam int unsigned AfullDef = 3;
   localparam int unsigned NumPorts = 3;

   // Source-port encoding reported on out_port.
   typedef enum logic [1:0] {
      PortU1 = 2'd0,
      PortU3 = 2'd1,
      PortU5 = 2'd2
   } port_e;

   // Round-robin successor: u1 -> u3 -> u5 -> u1.
   function automatic port_e next_port(port_e p);
      port_e n;
      case (p)
         PortU1:  n = PortU3;
         PortU3:  n = PortU5;
         default: n = PortU1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fpu_ret_collect_if.sv
// Bundle of return-port inputs and merged retirement outputs.
interface fpu_ret_collect_if;
   import fpu_ret_collect_pkg::*;

   logic [TagW-1:0] u1_ret;
   logic [TagW-1:0] u3_ret;
   logic [TagW-1:0] u5_ret;
   logic            u1_ret_en;
   logic            u3_ret_en;
   logic            u5_ret_en;
   logic [TagW-1:0] out_ret;
   logic [1:0]      out_port;
   logic            out_vld;
   logic            out_rdy;
   logic [2:0]      stall;
   logic [2:0]      ovf;

   // Driver side: FPU return ports plus the retirement consumer.
   modport master (
      output u1_ret, u3_ret, u5_ret, u1_ret_en, u3_ret_en, u5_ret_en, out_rdy,
      input  out_ret, out_port, out_vld, stall, ovf
   );

   // Collector side.
   modport slave (
      input  u1_ret, u3_ret, u5_ret, u1_ret_en, u3_ret_en, u5_ret_en, out_rdy,
      output out_ret, out_port, out_vld, stall, ovf
   );

endinterface

// File: rtl/fpu_ret_fifo.sv
// Single-in single-out tag FIFO with occupancy count, registered almost-full
// flag and sticky overflow flag.
module fpu_ret_fifo
   import fpu_ret_collect_pkg::*;
#(
   parameter int unsigned DEPTH = DepthDef,
   parameter int unsigned AFULL = AfullDef
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic [TagW-1:0] tag_i,
   input  logic            pop_i,
   output logic [TagW-1:0] tag_o,
   output logic            empty_o,
   output logic            afull_o,
   output logic            ovf_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL > DEPTH) begin : gen_param_err
      $error("fpu_ret_fifo: DEPTH must be a power of two >= 2 and AFULL <= DEPTH");
   end

   logic [TagW-1:0] mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            afull_q, afull_d;
   logic            ovf_q, ovf_d;
   logic            full, empty;
   logic            push_ok, pop_ok;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign tag_o   = mem_q[rd_ptr_q];
   assign empty_o = empty;
   assign afull_o = afull_q;
   assign ovf_o   = ovf_q;

   // Next-state: a full FIFO still accepts a push when it is popped the same cycle.
   always_comb begin
      pop_ok   = pop_i && !empty;
      push_ok  = push_i && (!full || pop_ok);
      wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      // Stall reflects occupancy after this cycle's push/pop.
      afull_d = (count_d >= CntW'(AFULL));
      ovf_d   = ovf_q || (push_i && !push_ok);
   end

   // Pointer, count and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array; contents are don't-care until written, so it has no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= tag_i;
      end
   end

endmodule

// File: rtl/fpu_ret_collect.sv
// Merges three FPU return ports into one retirement stream: per-port FIFOs,
// round-robin arbiter and a registered output stage with ready/valid.
module fpu_ret_collect
   import fpu_ret_collect_pkg::*;
#(
   parameter int unsigned DEPTH = DepthDef,
   parameter int unsigned AFULL = AfullDef
) (
   input logic               clk,
   input logic               rst,
   fpu_ret_collect_if.slave  bus_io
);

   logic [NumPorts-1:0] push;
   logic [NumPorts-1:0] pop;
   logic [NumPorts-1:0] empty;
   logic [NumPorts-1:0] afull;
   logic [NumPorts-1:0] ovf;
   logic [TagW-1:0]     tag_in  [NumPorts];
   logic [TagW-1:0]     tag_out [NumPorts];

   logic            out_vld_q, out_vld_d;
   logic [TagW-1:0] out_ret_q, out_ret_d;
   port_e           out_port_q, out_port_d;
   port_e           last_q, last_d;

   logic  load;
   logic  grant_vld;
   port_e grant;
   port_e cand;

   assign push      = {bus_io.u5_ret_en, bus_io.u3_ret_en, bus_io.u1_ret_en};
   assign tag_in[0] = bus_io.u1_ret;
   assign tag_in[1] = bus_io.u3_ret;
   assign tag_in[2] = bus_io.u5_ret;

   for (genvar i = 0; i < NumPorts; i++) begin : gen_fifo
      fpu_ret_fifo #(
         .DEPTH (DEPTH),
         .AFULL (AFULL)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[i]),
         .tag_i   (tag_in[i]),
         .pop_i   (pop[i]),
         .tag_o   (tag_out[i]),
         .empty_o (empty[i]),
         .afull_o (afull[i]),
         .ovf_o   (ovf[i])
      );
   end

   // Round-robin grant starting after the last granted port; load the output
   // stage when it is empty or being consumed, popping only the granted FIFO.
   always_comb begin
      load      = !out_vld_q || bus_io.out_rdy;
      grant     = last_q;
      grant_vld = 1'b0;
      cand      = next_port(last_q);
      for (int k = 0; k < 3; k++) begin
         if (!grant_vld && !empty[cand]) begin
            grant     = cand;
            grant_vld = 1'b1;
         end
         cand = next_port(cand);
      end

      pop        = '0;
      out_vld_d  = out_vld_q;
      out_ret_d  = out_ret_q;
      out_port_d = out_port_q;
      last_d     = last_q;
      if (load) begin
         out_vld_d = grant_vld;
         if (grant_vld) begin
            pop[grant] = 1'b1;
            out_ret_d  = tag_out[grant];
            out_port_d = grant;
            last_d     = grant;
         end
      end
   end

   // Output stage and arbiter history; last-granted resets to u5 so u1 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_ret_q  <= '0;
         out_port_q <= PortU1;
         last_q     <= PortU5;
      end else begin
         out_vld_q  <= out_vld_d;
         out_ret_q  <= out_ret_d;
         out_port_q <= out_port_d;
         last_q     <= last_d;
      end
   end

   assign bus_io.out_vld  = out_vld_q;
   assign bus_io.out_ret  = out_ret_q;
   assign bus_io.out_port = out_port_q;
   assign bus_io.stall    = afull;
   assign bus_io.ovf      = ovf;

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Directed self-checking bench for fpu_ret_collect (DEPTH=4, AFULL=3).
module tb_fpu_ret_collect;
   import fpu_ret_collect_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   fpu_ret_collect_if bus ();

   fpu_ret_collect #(
      .DEPTH (4),
      .AFULL (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.u1_ret_en = 1'b0;
      bus.u3_ret_en = 1'b0;
      bus.u5_ret_en = 1'b0;
      bus.u1_ret    = '0;
      bus.u3_ret    = '0;
      bus.u5_ret    = '0;
   endtask

   task automatic apply_reset;
      idle_inputs();
      bus.out_rdy = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reset values, with pushes offered during reset that must be ignored.
   task automatic test_reset;
      logic [22:0] obs;
      bus.out_rdy   = 1'b1;
      bus.u1_ret    = 14'h1234;
      bus.u1_ret_en = 1'b1;
      bus.u5_ret    = 14'h0555;
      bus.u5_ret_en = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {bus.out_vld, bus.out_port, bus.out_ret, bus.stall, bus.ovf};
         n_vec++;
         if (obs !== 23'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs, 23'h0);
         end
      end
      idle_inputs();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (bus.out_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ignores_inputs: out_vld got %b want 0", bus.out_vld);
         end
      end
   endtask

   // One u1 push: visible two cycles later, then nothing.
   task automatic test_single_push;
      apply_reset();
      bus.out_rdy   = 1'b1;
      bus.u1_ret    = 14'h0123;
      bus.u1_ret_en = 1'b1;
      tick();
      idle_inputs();
      n_vec++;
      if (bus.out_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL single_latency_n1: out_vld got %b want 0", bus.out_vld);
      end
      tick();
      n_vec++;
      if ({bus.out_vld, bus.out_port, bus.out_ret} !== {1'b1, 2'd0, 14'h0123}) begin
         n_bad++;
         $display("FAIL single_out: got vld=%b port=%0d ret=%h want vld=1 port=0 ret=0123",
                  bus.out_vld, bus.out_port, bus.out_ret);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++;
         if (bus.out_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after: out_vld got %b want 0", bus.out_vld);
         end
      end
   endtask

   // All three ports push in one cycle; retire u1, u3, u5 back to back.
   task automatic test_triple_push;
      logic [15:0] exp_q [3];
      exp_q[0] = {2'd0, 14'h0011};
      exp_q[1] = {2'd1, 14'h0022};
      exp_q[2] = {2'd2, 14'h0033};
      apply_reset();
      bus.out_rdy   = 1'b1;
      bus.u1_ret    = 14'h0011;
      bus.u3_ret    = 14'h0022;
      bus.u5_ret    = 14'h0033;
      bus.u1_ret_en = 1'b1;
      bus.u3_ret_en = 1'b1;
      bus.u5_ret_en = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if ({bus.out_vld, bus.out_port, bus.out_ret} !== {1'b1, exp_q[i]}) begin
            n_bad++;
            $display("FAIL triple_out%0d: got vld=%b port=%0d ret=%h want port=%0d ret=%h",
                     i, bus.out_vld, bus.out_port, bus.out_ret, exp_q[i][15:14],
                     exp_q[i][13:0]);
         end
      end
      tick();
      n_vec++;
      if (bus.out_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL triple_after: out_vld got %b want 0", bus.out_vld);
      end
   endtask

   // A held tag sits in the output stage; five more u3 pushes fill the FIFO
   // (stall after the third), drop the fifth (ovf), and drain as tags 1-4.
   task automatic test_backpressure;
      logic [TagW-1:0] base;
      logic            exp_stall;
      logic            exp_ovf;
      base = 14'h0300;
      apply_reset();
      bus.out_rdy   = 1'b0;
      bus.u3_ret    = base;
      bus.u3_ret_en = 1'b1;
      tick();
      idle_inputs();
      tick();
      n_vec++;
      if ({bus.out_vld, bus.out_port, bus.out_ret} !== {1'b1, 2'd1, base}) begin
         n_bad++;
         $display("FAIL bp_first: got vld=%b port=%0d ret=%h want vld=1 port=1 ret=%h",
                  bus.out_vld, bus.out_port, bus.out_ret, base);
      end
      for (int i = 1; i <= 5; i++) begin
         bus.u3_ret    = base + 14'(i);
         bus.u3_ret_en = 1'b1;
         tick();
         exp_stall = (i >= 3);
         exp_ovf   = (i >= 5);
         n_vec++;
         if ({bus.stall[1], bus.ovf[1], bus.out_vld, bus.out_ret} !==
             {exp_stall, exp_ovf, 1'b1, base}) begin
            n_bad++;
            $display("FAIL bp_push%0d: got stall=%b ovf=%b vld=%b ret=%h want %b %b 1 %h",
                     i, bus.stall[1], bus.ovf[1], bus.out_vld, bus.out_ret,
                     exp_stall, exp_ovf, base);
         end
      end
      idle_inputs();
      bus.out_rdy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_vec++;
         if ({bus.out_vld, bus.out_port, bus.out_ret} !== {1'b1, 2'd1, base + 14'(i)}) begin
            n_bad++;
            $display("FAIL bp_drain%0d: got vld=%b port=%0d ret=%h want vld=1 port=1 ret=%h",
                     i, bus.out_vld, bus.out_port, bus.out_ret, base + 14'(i));
         end
      end
      tick();
      n_vec++;
      if ({bus.out_vld, bus.ovf} !== {1'b0, 3'b010}) begin
         n_bad++;
         $display("FAIL bp_end: got vld=%b ovf=%b want vld=0 ovf=010", bus.out_vld, bus.ovf);
      end
   endtask

   // u5 FIFO full (4 entries) takes a push while being popped: no overflow,
   // and the new tag retires after the older ones.
   task automatic test_full_push_pop;
      logic [TagW-1:0] base;
      base = 14'h0500;
      apply_reset();
      bus.out_rdy   = 1'b0;
      bus.u5_ret    = base;
      bus.u5_ret_en = 1'b1;
      tick();
      idle_inputs();
      tick();
      for (int i = 1; i <= 4; i++) begin
         bus.u5_ret    = base + 14'(i);
         bus.u5_ret_en = 1'b1;
         tick();
      end
      bus.u5_ret    = base + 14'd5;
      bus.u5_ret_en = 1'b1;
      bus.out_rdy   = 1'b1;
      tick();
      idle_inputs();
      n_vec++;
      if ({bus.ovf[2], bus.stall[2], bus.out_ret} !== {1'b0, 1'b1, base + 14'd1}) begin
         n_bad++;
         $display("FAIL fpp_pushpop: got ovf=%b stall=%b ret=%h want ovf=0 stall=1 ret=%h",
                  bus.ovf[2], bus.stall[2], bus.out_ret, base + 14'd1);
      end
      for (int i = 2; i <= 5; i++) begin
         tick();
         n_vec++;
         if ({bus.out_vld, bus.out_port, bus.out_ret, bus.ovf[2]} !==
             {1'b1, 2'd2, base + 14'(i), 1'b0}) begin
            n_bad++;
            $display("FAIL fpp_drain%0d: got vld=%b port=%0d ret=%h ovf=%b want 1 2 %h 0",
                     i, bus.out_vld, bus.out_port, bus.out_ret, bus.ovf[2], base + 14'(i));
         end
      end
      tick();
      n_vec++;
      if (bus.out_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL fpp_end: out_vld got %b want 0", bus.out_vld);
      end
   endtask

   // All ports push every cycle; grants must rotate 0,1,2,0,...
   task automatic test_fairness;
      logic [1:0]      exp_port;
      logic [TagW-1:0] r;
      apply_reset();
      bus.out_rdy = 1'b1;
      for (int k = 0; k < 15; k++) begin
         bus.u1_ret    = 14'((0 << 8) | k);
         bus.u3_ret    = 14'((1 << 8) | k);
         bus.u5_ret    = 14'((2 << 8) | k);
         bus.u1_ret_en = 1'b1;
         bus.u3_ret_en = 1'b1;
         bus.u5_ret_en = 1'b1;
         tick();
         if (k >= 1) begin
            exp_port = 2'((k - 1) % 3);
            r        = bus.out_ret;
            n_vec++;
            if ({bus.out_vld, bus.out_port, r[13:8]} !== {1'b1, exp_port, 4'd0, exp_port}) begin
               n_bad++;
               $display("FAIL fair_grant%0d: got vld=%b port=%0d ret=%h want port=%0d",
                        k, bus.out_vld, bus.out_port, r, exp_port);
            end
         end
      end
      idle_inputs();
   endtask

   // One-cycle reset pulse with tags buffered: outputs drop at once and no
   // stale tag reappears.
   task automatic test_reset_midstream;
      logic [22:0] obs;
      apply_reset();
      bus.out_rdy   = 1'b0;
      bus.u1_ret    = 14'h0100;
      bus.u1_ret_en = 1'b1;
      tick();
      idle_inputs();
      tick();
      for (int i = 0; i < 5; i++) begin
         bus.u1_ret    = 14'h0101 + 14'(i);
         bus.u1_ret_en = (i < 2);
         bus.u5_ret    = 14'h0500 + 14'(i);
         bus.u5_ret_en = 1'b1;
         tick();
      end
      idle_inputs();
      n_vec++;
      if ({bus.out_vld, bus.stall[2], bus.ovf[2]} !== 3'b111) begin
         n_bad++;
         $display("FAIL rst_pre: got vld=%b stall2=%b ovf2=%b want 1 1 1",
                  bus.out_vld, bus.stall[2], bus.ovf[2]);
      end
      #2;
      rst = 1'b1;
      #1;
      obs = {bus.out_vld, bus.out_port, bus.out_ret, bus.stall, bus.ovf};
      n_vec++;
      if (obs !== 23'h0) begin
         n_bad++;
         $display("FAIL rst_async: got %h want %h", obs, 23'h0);
      end
      tick();
      rst = 1'b0;
      bus.out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (bus.out_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stale%0d: got vld=%b ret=%h want vld=0",
                     i, bus.out_vld, bus.out_ret);
         end
      end
      bus.u3_ret    = 14'h0777;
      bus.u3_ret_en = 1'b1;
      tick();
      idle_inputs();
      tick();
      n_vec++;
      if ({bus.out_vld, bus.out_port, bus.out_ret} !== {1'b1, 2'd1, 14'h0777}) begin
         n_bad++;
         $display("FAIL rst_fresh: got vld=%b port=%0d ret=%h want vld=1 port=1 ret=0777",
                  bus.out_vld, bus.out_port, bus.out_ret);
      end
   endtask

   initial begin
      idle_inputs();
      bus.out_rdy = 1'b0;
      test_reset();
      test_single_push();
      test_triple_push();
      test_backpressure();
      test_full_push_pop();
      test_fairness();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
